// File: rtl/game_state_regfile.sv
// Game-state register file: cell grid plus wide scalar bank, indexed write/read ports and a grid-clear sequencer.
// Define GAME_STATE_SNAPSHOT_EN to drive value_out from a frame-synchronous shadow copy.
module game_state_regfile #(
  parameter int unsigned       NUM_CELLS   = 100,
  parameter int unsigned       CELL_W      = 2,
  parameter int unsigned       NUM_SCALARS = 9,
  parameter int unsigned       SCALAR_W    = 32,
  parameter logic [CELL_W-1:0] CLEAR_VALUE = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic [31:0] index,
  input  logic        enable,
  input  logic [31:0] read_index,
  output logic [31:0] read_data,
  input  logic        clear_start,
  output logic        busy,
  output logic        clear_done,
  output logic        write_dropped,
  input  logic        frame_sync,
  output logic [NUM_CELLS*CELL_W+NUM_SCALARS*SCALAR_W-1:0] value_out
);

  localparam int unsigned STATE_W     = NUM_CELLS*CELL_W + NUM_SCALARS*SCALAR_W;
  localparam int unsigned CNT_W       = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [31:0] NUM_CELLS_32 = 32'(NUM_CELLS);
  localparam logic [31:0] NUM_ADDR_32  = 32'(NUM_CELLS + NUM_SCALARS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CELL_W-1:0]  cells   [NUM_CELLS];
  logic [SCALAR_W-1:0] scalars [NUM_SCALARS];
  logic [STATE_W-1:0] live_state;
  logic               clr_wr;
  logic               wr_ok;
  logic               wr_drop;
  logic [31:0]        rd_mux;
  logic [31:0]        rd_data_p1;
  logic               drop_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy       = 1'b0;
    clear_done = 1'b0;
    clr_wr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_wr = 1'b1;
        if (cnt_q == CNT_W'(NUM_CELLS - 1)) begin
          clear_done = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear request in the same cycle takes priority over the write.
  assign wr_ok   = (state_q == IDLE) && enable && !clear_start && (index < NUM_ADDR_32);
  assign wr_drop = enable && !wr_ok;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (read_index == 32'(i)) rd_mux = 32'(cells[i]);
    for (int j = 0; j < NUM_SCALARS; j++)
      if (read_index == NUM_CELLS_32 + 32'(j)) rd_mux = 32'(scalars[j]);
  end

  // ---- stage p1: storage update and registered read ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++)   cells[i]   <= '0;
      for (int j = 0; j < NUM_SCALARS; j++) scalars[j] <= '0;
      rd_data_p1 <= '0;
      drop_p1    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (clr_wr && cnt_q == CNT_W'(i))
          cells[i] <= CLEAR_VALUE;
        else if (wr_ok && index == 32'(i))
          cells[i] <= value_in[CELL_W-1:0];
      end
      for (int j = 0; j < NUM_SCALARS; j++)
        if (wr_ok && index == NUM_CELLS_32 + 32'(j))
          scalars[j] <= value_in[SCALAR_W-1:0];
      rd_data_p1 <= rd_mux;
      drop_p1    <= wr_drop;
    end
  end

  assign read_data     = rd_data_p1;
  assign write_dropped = drop_p1;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    assign live_state[i*CELL_W +: CELL_W] = cells[i];
  end
  for (genvar j = 0; j < NUM_SCALARS; j++) begin : g_scalar
    assign live_state[NUM_CELLS*CELL_W + j*SCALAR_W +: SCALAR_W] = scalars[j];
  end

`ifdef GAME_STATE_SNAPSHOT_EN
  logic [STATE_W-1:0] shadow;
  logic               snap_pend;

  // Vertical blank seen mid-clear is deferred so the renderer never sees a half-swept grid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      snap_pend <= 1'b0;
    end else if (state_q == IDLE) begin
      if (frame_sync || snap_pend) begin
        shadow    <= live_state;
        snap_pend <= 1'b0;
      end
    end else if (frame_sync) begin
      snap_pend <= 1'b1;
    end
  end

  assign value_out = shadow;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
  assign value_out = live_state;
`endif

endmodule

// File: tb/tb_game_state_regfile.sv
// Bench for game_state_regfile: directed steps plus random traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_game_state_regfile;
  localparam int NC  = 100;
  localparam int CW  = 2;
  localparam int NS  = 9;
  localparam int SW  = 32;
  localparam int VW  = NC*CW + NS*SW;
  localparam int NA  = NC + NS;
  localparam logic [CW-1:0] CLR = '0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   value_in = '0;
  logic [31:0]   index = '0;
  logic          enable = 1'b0;
  logic [31:0]   read_index = '0;
  logic [31:0]   read_data;
  logic          clear_start = 1'b0;
  logic          busy;
  logic          clear_done;
  logic          write_dropped;
  logic          frame_sync = 1'b0;
  logic [VW-1:0] value_out;

  always #5 clock = ~clock;

  game_state_regfile dut (
    .clock(clock), .reset(reset), .value_in(value_in), .index(index), .enable(enable),
    .read_index(read_index), .read_data(read_data), .clear_start(clear_start), .busy(busy),
    .clear_done(clear_done), .write_dropped(write_dropped), .frame_sync(frame_sync),
    .value_out(value_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: plain arrays plus the index of the next cell to sweep (-1 when not clearing).
  logic [CW-1:0] m_cells [NC];
  logic [SW-1:0] m_scal  [NS];
  int            m_clr;
  logic [31:0]   m_rd;
  logic          m_drop;
  logic [VW-1:0] m_shadow;
  bit            m_pend;

  function automatic logic [VW-1:0] model_flat();
    logic [VW-1:0] f;
    f = '0;
    for (int i = 0; i < NC; i++) f[i*CW +: CW] = m_cells[i];
    for (int j = 0; j < NS; j++) f[NC*CW + j*SW +: SW] = m_scal[j];
    return f;
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    if (a < NC) return 32'(m_cells[a]);
    if (a < NA) return m_scal[a - NC];
    return 32'd0;
  endfunction

  function automatic logic [VW-1:0] exp_value_out();
`ifdef GAME_STATE_SNAPSHOT_EN
    return m_shadow;
`else
    return model_flat();
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cells[i] = '0;
    for (int j = 0; j < NS; j++) m_scal[j] = '0;
    m_clr = -1; m_rd = '0; m_drop = 1'b0; m_shadow = '0; m_pend = 1'b0;
  endtask

  task automatic model_edge();
    bit            idle;
    logic [VW-1:0] pre;
    idle   = (m_clr < 0);
    pre    = model_flat();
    m_rd   = ref_read(read_index);
    m_drop = enable && (!idle || clear_start || index >= NA);
`ifdef GAME_STATE_SNAPSHOT_EN
    if (idle && (frame_sync || m_pend)) begin
      m_shadow = pre;
      m_pend   = 1'b0;
    end else if (!idle && frame_sync) begin
      m_pend = 1'b1;
    end
`endif
    if (idle && enable && !clear_start && index < NA) begin
      if (index < NC) m_cells[index] = value_in[CW-1:0];
      else            m_scal[index - NC] = value_in[SW-1:0];
    end
    if (!idle) begin
      m_cells[m_clr] = CLR;
      m_clr = (m_clr == NC-1) ? -1 : m_clr + 1;
    end else if (clear_start) begin
      m_clr = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".value_out"}, value_out, exp_value_out());
    check({tag, ".read_data"}, read_data, m_rd);
    check({tag, ".busy"}, busy, (m_clr >= 0));
    check({tag, ".clear_done"}, clear_done, (m_clr == NC-1));
    check({tag, ".write_dropped"}, write_dropped, m_drop);
  endtask

  task automatic idle_inputs();
    enable = 1'b0; clear_start = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic apply_reset(string tag);
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic write(logic [31:0] a, logic [31:0] v);
    enable = 1'b1; index = a; value_in = v;
    tick();
    enable = 1'b0;
    check_all("write");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_at, done_cnt, guard;
    #2;
    apply_reset("reset");

    // Single cell write and readback
    write(32'd5, 32'd3);
`ifndef GAME_STATE_SNAPSHOT_EN
    check("cell5.slice", value_out[11:10], 2'b11);
`endif
    read_index = 32'd5;
    tick(); check_all("read5");
    check("read5.data", read_data, 32'd3);

    // Scalars and out-of-range writes
    write(32'd100, 32'hDEADBEEF);
    write(32'd108, 32'h12345678);
`ifndef GAME_STATE_SNAPSHOT_EN
    check("scalar0.slice", value_out[231:200], 32'hDEADBEEF);
    check("scalar8.slice", value_out[487:456], 32'h12345678);
`endif
    write(32'd109, 32'hFFFFFFFF);
    check("drop109", write_dropped, 1'b1);
    write(32'h8000_0005, 32'h1);
    check("drop_hi_bits", write_dropped, 1'b1);
    read_index = 32'h0001_0064;
    tick(); check_all("read_hi_bits");
    check("read_oor.data", read_data, 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      enable      = $urandom_range(0, 1);
      index       = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NA + 5));
      read_index  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NA + 5));
      value_in    = $urandom;
      clear_start = ($urandom_range(0, 49) == 0);
      frame_sync  = ($urandom_range(0, 7) == 0);
      tick(); check_all("random");
    end
    idle_inputs();
    guard = 0;
    while (m_clr >= 0 && guard < 200) begin
      tick(); check_all("drain"); guard++;
    end

    // Full grid fill followed by a clear sweep
    for (int i = 0; i < NC; i++) write(32'(i), 32'hFFFF_FFF2);
    clear_start = 1'b1;
    tick(); check_all("clr_start");
    clear_start = 1'b0;
    busy_cnt = 0; done_at = 0; done_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      if (clear_done === 1'b1) begin done_cnt++; done_at = busy_cnt; end
      read_index = 32'($urandom_range(0, NA - 1));
      tick(); check_all("clear");
    end
    check("clear.busy_cycles", 32'(busy_cnt), 32'd100);
    check("clear.done_count", 32'(done_cnt), 32'd1);
    check("clear.done_cycle", 32'(done_at), 32'd100);
    for (int i = 0; i < NA; i++) begin
      read_index = 32'(i);
      tick(); check_all("post_clear_read");
      if (i < NC) check("post_clear.cell", read_data, 32'(CLR));
    end

    // Collisions during a clear
    write(32'd3, 32'd2);
    clear_start = 1'b1;
    tick(); check_all("clr2_start");
    clear_start = 1'b0;
    busy_cnt = 0; done_at = 0;
    while (busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      if (clear_done === 1'b1) done_at = busy_cnt;
      if (busy_cnt == 40) begin
        enable = 1'b1; index = 32'd3; value_in = 32'd1; clear_start = 1'b1;
      end else begin
        enable = 1'b0; clear_start = 1'b0;
      end
      tick(); check_all("midclr");
      if (busy_cnt == 40) check("midclr.drop", write_dropped, 1'b1);
    end
    check("midclr.done_cycle", 32'(done_at), 32'd100);
    check("midclr.busy_cycles", 32'(busy_cnt), 32'd100);
    idle_inputs();
    read_index = 32'd3;
    tick(); check_all("midclr.read3");
    check("midclr.cell3", read_data, 32'd0);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    tick(); check_all("clr3_start");
    clear_start = 1'b0;
    for (int k = 1; k < 50; k++) begin tick(); check_all("clr3"); end
    apply_reset("reset_midclear");
    check("reset_midclear.busy", busy, 1'b0);
    check("reset_midclear.state", value_out, '0);
    done_cnt = 0;
    for (int k = 0; k < 120; k++) begin
      tick(); check_all("after_reset");
      if (clear_done === 1'b1) done_cnt++;
    end
    check("after_reset.no_done", 32'(done_cnt), 32'd0);

`ifdef GAME_STATE_SNAPSHOT_EN
    // Shadow copy follows frame_sync only
    write(32'd7, 32'd1);
    tick(); check_all("snap_hold");
    check("snap.before_sync", value_out[15:14], 2'b00);
    frame_sync = 1'b1;
    tick(); check_all("snap_sync");
    frame_sync = 1'b0;
    check("snap.after_sync", value_out[15:14], 2'b01);
    clear_start = 1'b1;
    tick(); check_all("snap_clr_start");
    clear_start = 1'b0;
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      frame_sync = (busy_cnt == 10);
      tick(); check_all("snap_clear");
    end
    frame_sync = 1'b0;
    check("snap.pending_hold", value_out[15:14], 2'b01);
    tick(); check_all("snap_deferred");
    check("snap.deferred_load", value_out[15:14], 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
